// File: rtl/action_ram_client.sv
// action_ram_client: serialized READ / WRITE / saturating ADD / CLEAR front end
// for the action_ram. It drives the RAM's write_address, d_in, write_enable
// and read_address and consumes d_out.
//
// Command handshake: a command is accepted on a rising edge where
// cmd_valid && cmd_ready. cmd_ready is high only in IDLE, so commands are
// strictly serialized. cmd_* need only be stable during the accepting cycle.
// rsp_valid is a one-cycle completion pulse with no backpressure.
module action_ram_client #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1   // legal range 1..3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic [DATA_WIDTH-1:0] ram_d_in,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_d_out,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        ADD_WAIT = 3'd2,
        ADD_WR   = 3'd3,
        CLEAR    = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Number of edges to wait after presenting the read address before
    // d_out is sampled on the following edge.
    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  state_q;
    logic [1:0]              wait_q;
    logic [ADDR_WIDTH-1:0]   sweep_q;
    logic [DATA_WIDTH-1:0]   delta_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   d_in_q;
    logic                    we_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic [DATA_WIDTH-1:0]   sum_d;
    logic                    ovf_d;
    logic [DATA_WIDTH-1:0]   add_d;
    logic [ADDR_WIDTH-1:0]   sweep_d;

    // Signed saturating sum of the stored value and the latched delta,
    // plus the next sweep address for CLEAR.
    always_comb begin
        sum_d   = ram_d_out + delta_q;
        ovf_d   = 1'b0;
        add_d   = sum_d;
        sweep_d = sweep_q + ADDR_WIDTH'(1);
        // Overflow only when both operands share a sign the result lacks.
        if ((ram_d_out[DATA_WIDTH-1] == delta_q[DATA_WIDTH-1]) &&
            (sum_d[DATA_WIDTH-1] != ram_d_out[DATA_WIDTH-1])) begin
            ovf_d = 1'b1;
        end
        if (ovf_d) begin
            add_d = ram_d_out[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Main controller: state, counters and every registered output.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wait_q      <= 2'd0;
            sweep_q     <= '0;
            delta_q     <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            d_in_q      <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_READ: begin
                                rd_addr_q <= cmd_addr;
                                wait_q    <= 2'd0;
                                state_q   <= RD_WAIT;
                            end
                            OP_WRITE: begin
                                // Completes in the cycle after accept, staying
                                // in IDLE so writes can stream every cycle.
                                wr_addr_q   <= cmd_addr;
                                d_in_q      <= cmd_data;
                                we_q        <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= cmd_data;
                            end
                            OP_ADD: begin
                                rd_addr_q <= cmd_addr;
                                delta_q   <= cmd_data;
                                wait_q    <= 2'd0;
                                state_q   <= ADD_WAIT;
                            end
                            default: begin
                                // CLEAR: the first sweep write (address 0)
                                // is issued right away.
                                sweep_q   <= '0;
                                wr_addr_q <= '0;
                                d_in_q    <= '0;
                                we_q      <= 1'b1;
                                state_q   <= CLEAR;
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    if (wait_q == LAT) begin
                        rsp_data_q  <= ram_d_out;
                        rsp_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                ADD_WAIT: begin
                    if (wait_q == LAT) begin
                        wr_addr_q   <= rd_addr_q;
                        d_in_q      <= add_d;
                        we_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= add_d;
                        state_q     <= ADD_WR;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                ADD_WR: begin
                    // Write strobe and response are visible this cycle.
                    state_q <= IDLE;
                end
                CLEAR: begin
                    if (sweep_q == LAST_ADDR) begin
                        // Last address has just been written; no wrap.
                        state_q <= IDLE;
                    end else begin
                        sweep_q     <= sweep_d;
                        wr_addr_q   <= sweep_d;
                        d_in_q      <= '0;
                        we_q        <= 1'b1;
                        rsp_valid_q <= (sweep_d == LAST_ADDR);
                        if (sweep_d == LAST_ADDR) begin
                            rsp_data_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready         = (state_q == IDLE);
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign ram_read_address  = rd_addr_q;
    assign ram_write_address = wr_addr_q;
    assign ram_d_in          = d_in_q;
    assign ram_write_enable  = we_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_action_ram_client.sv
// Bench for action_ram_client with a behavioural action_ram attached.
module tb_action_ram_client;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] ram_read_address;
    logic [AW-1:0] ram_write_address;
    logic [DW-1:0] ram_d_in;
    logic          ram_write_enable;
    logic [DW-1:0] ram_d_out;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    // Monitor counters
    int we_cnt = 0;
    int rsp_cnt = 0;
    int run = 0;
    int last_run = 0;
    int clr_ready_bad = 0;
    int clr_rsp_bad = 0;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [0:28];

    // Clock
    always #5 clock = ~clock;

    action_ram_client #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .ram_read_address(ram_read_address),
        .ram_write_address(ram_write_address),
        .ram_d_in(ram_d_in),
        .ram_write_enable(ram_write_enable),
        .ram_d_out(ram_d_out),
        .dbg_state(dbg_state)
    );

    // Behavioural action_ram: write commits on the edge ending the strobe
    // cycle; d_out is valid RL edges after read_address is presented.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:RL-1];

    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_write_address] <= ram_d_in;
        rd_pipe[0] <= mem[ram_read_address];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_d_out = rd_pipe[RL-1];

    // Cycle monitor, sampled away from the active edge.
    always @(negedge clock) begin
        if (ram_write_enable) begin
            we_cnt = we_cnt + 1;
            run = run + 1;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
        if (dbg_state == 3'd4 && cmd_ready) clr_ready_bad = clr_ready_bad + 1;
        if (rsp_valid && dbg_state == 3'd4 && ram_write_address != 8'hFF)
            clr_rsp_bad = clr_rsp_bad + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            2'b01:   return 0;
            2'b11:   return (1 << AW) - 1;
            default: return RL + 1;
        endcase
    endfunction

    // Drive one command from a negedge, wait for acceptance and its
    // response, and check response data and latency (edges after accept).
    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] exp,
                          input string name);
        int tries;
        int lat;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tries = 0;
        while (!cmd_ready && tries < 20) begin
            @(negedge clock);
            tries++;
        end
        chk({name, " ready"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(negedge clock);
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat(op));
        chk({name, " rsp_data"}, {16'd0, rsp_data}, {16'd0, exp});
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp,
                   $sformatf("vec%0d", i));
    endtask

    int we0, rsp0, crb0, crs0;

    initial begin
        // Vector table: op, addr, data, expected rsp_data
        vecs[0] = '{2'b01, 8'h20, 16'h0002, 16'h0002};   // WRITE
        vecs[1] = '{2'b00, 8'h20, 16'h0000, 16'h0002};   // READ right after WRITE
        for (int k = 0; k < 6; k++) begin
            vecs[2+k] = '{2'b01, 8'(8'h20 + k), 16'(2 + k), 16'(2 + k)};
            vecs[8+k] = '{2'b00, 8'(8'h20 + k), 16'h0000, 16'(2 + k)};
        end
        vecs[14] = '{2'b01, 8'h10, 16'h7FF0, 16'h7FF0};
        vecs[15] = '{2'b10, 8'h10, 16'h0020, 16'h7FFF};  // positive saturation
        vecs[16] = '{2'b10, 8'h10, 16'hFFFF, 16'h7FFE};
        vecs[17] = '{2'b00, 8'h10, 16'h0000, 16'h7FFE};
        vecs[18] = '{2'b01, 8'h11, 16'h8005, 16'h8005};
        vecs[19] = '{2'b10, 8'h11, 16'hFFF0, 16'h8000};  // negative saturation
        vecs[20] = '{2'b01, 8'h12, 16'h0100, 16'h0100};
        vecs[21] = '{2'b10, 8'h12, 16'hFF00, 16'h0000};
        vecs[22] = '{2'b10, 8'h12, 16'h8000, 16'h8000};  // exactly min, no overflow
        vecs[23] = '{2'b10, 8'h12, 16'hFFFF, 16'h8000};  // min - 1 saturates
        vecs[24] = '{2'b10, 8'h12, 16'h7FFF, 16'hFFFF};
        vecs[25] = '{2'b00, 8'h12, 16'h0000, 16'hFFFF};
        vecs[26] = '{2'b01, 8'h00, 16'h1111, 16'h1111};
        vecs[27] = '{2'b01, 8'h7F, 16'h2222, 16'h2222};
        vecs[28] = '{2'b01, 8'hFF, 16'h3333, 16'h3333};

        // Reset with a pending WRITE request
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 8'h33;
        cmd_data  = 16'hABCD;
        repeat (2) @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        #1;
        chk("reset we_cnt", we_cnt, 0);
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("reset ram_read_address", {24'd0, ram_read_address}, 32'd0);
        chk("reset ram_write_address", {24'd0, ram_write_address}, 32'd0);
        chk("reset ram_d_in", {16'd0, ram_d_in}, 32'd0);
        chk("reset ram_write_enable", {31'd0, ram_write_enable}, 32'd0);
        chk("reset state", {29'd0, dbg_state}, 32'd0);
        reset_n = 1'b1;

        // WRITE then READ of the same address
        apply(0, 1);

        // Back-to-back WRITEs and readback
        #1;
        we0  = we_cnt;
        rsp0 = rsp_cnt;
        apply(2, 13);
        #1;
        chk("b2b write strobes", we_cnt - we0, 6);
        chk("b2b strobe run", last_run, 6);
        chk("b2b rsp pulses", rsp_cnt - rsp0, 12);

        // ADD saturation and preload for CLEAR
        apply(14, 28);

        // Full CLEAR
        #1;
        we0  = we_cnt;
        rsp0 = rsp_cnt;
        crb0 = clr_ready_bad;
        crs0 = clr_rsp_bad;
        do_cmd(2'b11, 8'h55, 16'h9999, 16'h0000, "clear");
        repeat (2) @(negedge clock);
        #1;
        chk("clear strobes", we_cnt - we0, 256);
        chk("clear rsp pulses", rsp_cnt - rsp0, 1);
        chk("clear cmd_ready low", clr_ready_bad - crb0, 0);
        chk("clear rsp on last addr", clr_rsp_bad - crs0, 0);
        chk("clear back to idle", {29'd0, dbg_state}, 32'd0);
        do_cmd(2'b00, 8'h00, 16'h0, 16'h0000, "clr rd 00");
        do_cmd(2'b00, 8'h7F, 16'h0, 16'h0000, "clr rd 7f");
        do_cmd(2'b00, 8'hFF, 16'h0, 16'h0000, "clr rd ff");
        do_cmd(2'b00, 8'h12, 16'h0, 16'h0000, "clr rd 12");

        // Reset in the middle of a CLEAR sweep
        do_cmd(2'b01, 8'h7F, 16'h4444, 16'h4444, "pre 7f");
        do_cmd(2'b01, 8'h05, 16'h5555, 16'h5555, "pre 05");
        do_cmd(2'b01, 8'h0A, 16'h6666, 16'h6666, "pre 0a");
        #1;
        we0 = we_cnt;
        cmd_op    = 2'b11;
        cmd_addr  = 8'h00;
        cmd_data  = 16'h0000;
        cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clock);
        chk("midclr write addr", {24'd0, ram_write_address}, 32'd9);
        chk("midclr strobe", {31'd0, ram_write_enable}, 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        chk("midclr we after reset", {31'd0, ram_write_enable}, 32'd0);
        chk("midclr state", {29'd0, dbg_state}, 32'd0);
        chk("midclr cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midclr rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midclr strobes", we_cnt - we0, 10);
        @(negedge clock);
        reset_n = 1'b1;
        do_cmd(2'b00, 8'h7F, 16'h0, 16'h4444, "midclr rd 7f");
        do_cmd(2'b00, 8'h05, 16'h0, 16'h0000, "midclr rd 05");
        do_cmd(2'b00, 8'h0A, 16'h0, 16'h6666, "midclr rd 0a");

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
